// File: rtl/word_load_ctrl.sv
// word_load_ctrl
//   Assembles a 32-bit word from a 16-bit switch bank, one half at a time.
//   BTNL requests a load of the upper half, BTNR a load of the lower half.
//   Each button is synchronised, debounced and edge-detected. The result is a
//   sticky request that a four-state sequencer services. The sequencer strobes
//   ld_hi / ld_lo and closes every sequence with a single upd pulse. The word
//   is shown as eight hex digits on a multiplexed seven-segment display.
//
//   Optional feature: define WORD_LOAD_CTRL_ZERO_BLANK_EN to blank the digits
//   above the most significant nonzero nibble. Digit 0 always shows.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive equal samples needed before a new button
//                    level is accepted (2..2^20)
//   SCAN_DIV         clock cycles each display digit is driven (2..2^20)
//
// Ports
//   clk        single clock, rising edge
//   RST_BTN_n  asynchronous active-low reset
//   SW[15:0]   value captured into the half-word being loaded
//   BTNL/BTNR  raw buttons: load upper / lower half
//   ld_hi      one-cycle strobe while the upper half is loaded
//   ld_lo      one-cycle strobe while the lower half is loaded
//   word[31:0] assembled word {upper, lower}
//   valid      both halves have been loaded at least once since reset
//   upd        one-cycle pulse when a load sequence commits
//   busy       sequencer is not idle
//   an[7:0]    digit enables, active-low one-hot
//   cc[6:0]    segments {g,f,e,d,c,b,a}, active-low
module word_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 1024
) (
    input  logic        clk,
    input  logic        RST_BTN_n,
    input  logic [15:0] SW,
    input  logic        BTNL,
    input  logic        BTNR,
    output logic        ld_hi,
    output logic        ld_lo,
    output logic [31:0] word,
    output logic        valid,
    output logic        upd,
    output logic        busy,
    output logic [7:0]  an,
    output logic [6:0]  cc
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, COMMIT} state_t;

    // Button vectors: bit 1 = left (upper half), bit 0 = right (lower half).
    logic [1:0]      btn_raw, sync1, sync2, level, accept, req;
    logic [DB_W-1:0] db_cnt [2];
    state_t          state, state_next;
    logic            pend_l, pend_r, hi_seen, lo_seen;
    logic [SC_W-1:0] scan_cnt;
    logic [2:0]      digit;

    assign btn_raw = {BTNL, BTNR};

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values present before the edge whatever the process order is.
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A new level is accepted on the DEBOUNCE_CYCLES-th consecutive sample
    // that differs from the current one. Only a press (new level 1) requests.
    always_comb begin
        accept = '0;
        req    = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync2[i] != level[i]) && (db_cnt[i] == DB_LAST);
            req[i]    = accept[i] && sync2[i];
        end
    end

    // NOTE: the counter array is only two small registers, so it is reset like
    // any other flop. This returns both debouncers to the released state.
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            level <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequencer: state register
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) state <= IDLE;
        else            state <= state_next;
    end

    // Sequencer: next state. The upper half goes first, so simultaneous
    // requests produce LOAD_HI, LOAD_LO, COMMIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pend_l)      state_next = LOAD_HI;
                else if (pend_r) state_next = LOAD_LO;
            end
            LOAD_HI: state_next = pend_r ? LOAD_LO : COMMIT;
            LOAD_LO: state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        ld_hi = 1'b0;
        ld_lo = 1'b0;
        upd   = 1'b0;
        busy  = (state != IDLE);
        case (state)
            LOAD_HI: ld_hi = 1'b1;
            LOAD_LO: ld_lo = 1'b1;
            COMMIT:  upd   = 1'b1;
            default: ;
        endcase
    end

    // Pending flags, word halves and the valid flag. A flag is cleared in the
    // cycle it is serviced. A request landing in that same cycle keeps it set.
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            pend_l  <= 1'b0;
            pend_r  <= 1'b0;
            word    <= '0;
            hi_seen <= 1'b0;
            lo_seen <= 1'b0;
            valid   <= 1'b0;
        end else begin
            pend_l <= (pend_l && (state != LOAD_HI)) || req[1];
            pend_r <= (pend_r && (state != LOAD_LO)) || req[0];
            if (state == LOAD_HI) begin
                word[31:16] <= SW;
                hi_seen     <= 1'b1;
            end
            if (state == LOAD_LO) begin
                word[15:0] <= SW;
                lo_seen    <= 1'b1;
            end
            if (state == COMMIT && hi_seen && lo_seen) valid <= 1'b1;
        end
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'b1111111;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [31:0] w, input logic [2:0] d);
        logic [6:0] g;
        g = hex_glyph(w[{d, 2'b00} +: 4]);
`ifdef WORD_LOAD_CTRL_ZERO_BLANK_EN
        // Blank when this nibble and every nibble above it are zero.
        if (d != 3'd0 && (w >> {d, 2'b00}) == 32'd0) g = 7'b1111111;
`endif
        return g;
    endfunction

    // Display scan. The segment pattern is registered together with the digit
    // change. A new word therefore shows from the next digit drive onward.
    always_ff @(posedge clk or negedge RST_BTN_n) begin
        if (!RST_BTN_n) begin
            scan_cnt <= '0;
            digit    <= 3'd0;
            cc       <= 7'b1000000;
        end else if (scan_cnt == SC_LAST) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
            cc       <= digit_glyph(word, digit + 3'd1);
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign an = ~(8'b0000_0001 << digit);

endmodule

// File: tb/tb_word_load_ctrl.sv
// Testbench for word_load_ctrl.
//   A behavioural model predicts every output on every cycle. Button handling
//   is modelled as a sliding window of raw samples. Sequencing follows the
//   request/service rules, and the display follows elapsed time since reset.
//   Directed scenarios add hand-computed literal expectations on top.
//   Honours WORD_LOAD_CTRL_ZERO_BLANK_EN for the expected blank digits.
module tb_word_load_ctrl;

    localparam int DEB  = 8;
    localparam int SCAN = 4;
`ifdef WORD_LOAD_CTRL_ZERO_BLANK_EN
    localparam logic [6:0] HIGH_ZERO_EXP = 7'b1111111;
`else
    localparam logic [6:0] HIGH_ZERO_EXP = 7'b1000000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] SW = '0;
    logic        BTNL = 1'b0, BTNR = 1'b0;
    logic        ld_hi, ld_lo, valid, upd, busy;
    logic [31:0] word;
    logic [7:0]  an;
    logic [6:0]  cc;

    always #5 clk = ~clk;

    word_load_ctrl #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
        .clk(clk), .RST_BTN_n(rst_n), .SW(SW), .BTNL(BTNL), .BTNR(BTNR),
        .ld_hi(ld_hi), .ld_lo(ld_lo), .word(word), .valid(valid), .upd(upd),
        .busy(busy), .an(an), .cc(cc)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Standard active-low hex glyphs {g,f,e,d,c,b,a}
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [6:0] glyph(input logic [31:0] w, input int d);
        int msd;
        msd = 0;
`ifdef WORD_LOAD_CTRL_ZERO_BLANK_EN
        for (int i = 0; i < 8; i++) if (((w >> (4 * i)) & 32'hF) != 0) msd = i;
        if (d > msd) return 7'b1111111;
`endif
        return seg_tab[(w >> (4 * d)) & 32'hF];
    endfunction

    // ---------------- behavioural model ----------------
    bit          hist_l[$], hist_r[$];   // raw samples, newest first
    bit          lvl_l, lvl_r, m_pend_l, m_pend_r, m_hi_seen, m_lo_seen, m_valid;
    byte         cur = "I";              // activity of the current cycle
    byte         nxt;
    logic [31:0] m_word = '0, word_pre;
    int          m_tick = 0, m_digit = 0;
    logic [6:0]  m_cc = 7'h40;
    bit          acc_l, acc_r, req_l, req_r;

    // The synchroniser delays samples by two edges. A new level needs the DEB
    // delayed samples to agree and to differ from the accepted level.
    function automatic bit settled(input bit h[$], input bit v);
        for (int k = 2; k < DEB + 2; k++) if (h[k] != v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        hist_l = {};
        hist_r = {};
        for (int k = 0; k < DEB + 2; k++) begin
            hist_l.push_back(1'b0);
            hist_r.push_back(1'b0);
        end
        lvl_l = 0; lvl_r = 0; m_pend_l = 0; m_pend_r = 0;
        m_hi_seen = 0; m_lo_seen = 0; m_valid = 0;
        cur = "I"; m_word = '0; m_tick = 0; m_digit = 0; m_cc = 7'h40;
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            hist_l.push_front(BTNL);
            hist_r.push_front(BTNR);
            if (hist_l.size() > DEB + 2) void'(hist_l.pop_back());
            if (hist_r.size() > DEB + 2) void'(hist_r.pop_back());
            acc_l = settled(hist_l, !lvl_l);
            acc_r = settled(hist_r, !lvl_r);
            req_l = acc_l && !lvl_l;
            req_r = acc_r && !lvl_r;
            if (acc_l) lvl_l = !lvl_l;
            if (acc_r) lvl_r = !lvl_r;

            word_pre = m_word;
            nxt = "I";
            case (cur)
                "I": nxt = m_pend_l ? "H" : (m_pend_r ? "L" : "I");
                "H": begin m_word[31:16] = SW; m_hi_seen = 1; nxt = m_pend_r ? "L" : "C"; end
                "L": begin m_word[15:0]  = SW; m_lo_seen = 1; nxt = "C"; end
                "C": begin if (m_hi_seen && m_lo_seen) m_valid = 1; nxt = "I"; end
                default: nxt = "I";
            endcase
            m_pend_l = (m_pend_l && cur != "H") || req_l;
            m_pend_r = (m_pend_r && cur != "L") || req_r;
            cur = nxt;

            m_tick++;
            if (m_tick % SCAN == 0) begin
                m_digit = (m_digit + 1) % 8;
                m_cc    = glyph(word_pre, m_digit);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int         cyc = 0, n_hi = 0, n_lo = 0, n_upd = 0, hi_cyc = 0, lo_cyc = 0;
    logic [7:0] e_an;

    always @(negedge clk) begin
        cyc++;
        e_an = ~(8'b1 << m_digit);
        check("cycle_outputs", {ld_hi, ld_lo, upd, busy, valid, word, an, cc},
              {cur == "H", cur == "L", cur == "C", cur != "I", m_valid, m_word, e_an, m_cc});
        if (ld_hi) begin n_hi++; hi_cyc = cyc; end
        if (ld_lo) begin n_lo++; lo_cyc = cyc; end
        if (upd)   n_upd++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic press(input bit l, input bit r, input int hold);
        @(negedge clk);
        BTNL = l;
        BTNR = r;
        repeat (hold) @(negedge clk);
        BTNL = 0;
        BTNR = 0;
        repeat (DEB + 12) @(negedge clk);
    endtask

    initial begin
        int         h0, l0, u0, idx;
        logic [6:0] shown [8];

        repeat (3) @(negedge clk);
        check("reset_an", an, 8'hFE);
        check("reset_cc", cc, 7'h40);
        check("reset_word", word, 32'h0);
        check("reset_strobes", {ld_hi, ld_lo, upd, busy, valid}, 5'b0);
        #2 rst_n = 1;
        repeat (5) @(negedge clk);

        // Upper half load
        SW = 16'hABCD;
        h0 = n_hi; l0 = n_lo; u0 = n_upd;
        press(1, 0, 2 * DEB);
        check("s1_ld_hi_count", n_hi - h0, 1);
        check("s1_ld_lo_count", n_lo - l0, 0);
        check("s1_upd_count", n_upd - u0, 1);
        check("s1_word", word, 32'hABCD0000);
        check("s1_valid", valid, 0);

        // Lower half load
        SW = 16'h1234;
        h0 = n_hi; l0 = n_lo;
        press(0, 1, 2 * DEB);
        check("s2_ld_lo_count", n_lo - l0, 1);
        check("s2_ld_hi_count", n_hi - h0, 0);
        check("s2_word", word, 32'hABCD1234);
        check("s2_valid", valid, 1);

        // Simultaneous presses
        SW = 16'h00FF;
        h0 = n_hi; l0 = n_lo; u0 = n_upd;
        press(1, 1, 2 * DEB);
        check("s3_ld_hi_count", n_hi - h0, 1);
        check("s3_ld_lo_count", n_lo - l0, 1);
        check("s3_order", lo_cyc - hi_cyc, 1);
        check("s3_upd_count", n_upd - u0, 1);
        check("s3_word", word, 32'h00FF00FF);

        // Bounce one sample short, then a long hold
        SW = 16'h5555;
        h0 = n_hi;
        @(negedge clk);
        BTNL = 1;
        repeat (DEB - 1) @(negedge clk);
        BTNL = 0;
        repeat (DEB + 12) @(negedge clk);
        check("s4_bounce_no_strobe", n_hi - h0, 0);
        press(1, 0, 10000);
        check("s4_hold_one_strobe", n_hi - h0, 1);
        check("s4_word", word, 32'h555500FF);

        // Right request lands while the left sequence is running
        SW = 16'h0000;
        h0 = n_hi; l0 = n_lo; u0 = n_upd;
        @(negedge clk);
        BTNL = 1;
        repeat (2) @(negedge clk);
        BTNR = 1;
        repeat (2 * DEB) @(negedge clk);
        BTNL = 0;
        BTNR = 0;
        repeat (DEB + 12) @(negedge clk);
        check("s5_ld_hi_count", n_hi - h0, 1);
        check("s5_ld_lo_count", n_lo - l0, 1);
        check("s5_upd_count", n_upd - u0, 2);
        check("s5_word", word, 32'h0);

        // Display of 0000A008
        SW = 16'hA008;
        press(0, 1, 2 * DEB);
        check("s6_word", word, 32'h0000A008);
        repeat (9 * SCAN) @(negedge clk);
        for (int k = 0; k < 8; k++) shown[k] = 7'h55;
        for (int t = 0; t < 8 * SCAN; t++) begin
            idx = 0;
            for (int k = 0; k < 8; k++) if (an[k] == 1'b0) idx = k;
            shown[idx] = cc;
            @(negedge clk);
        end
        check("s6_digit0", shown[0], 7'b0000000);
        check("s6_digit1", shown[1], 7'b1000000);
        check("s6_digit2", shown[2], 7'b1000000);
        check("s6_digit3", shown[3], 7'b0001000);
        for (int k = 4; k < 8; k++) check($sformatf("s6_digit%0d", k), shown[k], HIGH_ZERO_EXP);

        // Reset during LOAD_HI of a two-half sequence
        SW = 16'h7777;
        @(negedge clk);
        BTNL = 1;
        BTNR = 1;
        for (int t = 0; t < 100 && !ld_hi; t++) @(negedge clk);
        check("s7_reached_load_hi", ld_hi, 1);
        BTNL = 0;
        BTNR = 0;
        l0 = n_lo; u0 = n_upd;
        #2 rst_n = 0;
        #1;
        check("s7_reset_strobes", {ld_hi, ld_lo, upd, busy, valid}, 5'b0);
        check("s7_reset_word", word, 32'h0);
        check("s7_reset_an", an, 8'hFE);
        check("s7_reset_cc", cc, 7'h40);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        repeat (40) @(negedge clk);
        check("s7_no_ld_lo", n_lo - l0, 0);
        check("s7_no_upd", n_upd - u0, 0);
        check("s7_word", word, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
